fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the rv32i core. It replaces the single-cycle combinational instruction fetch currently exercised by the top-level bench.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses of variable latency.
- Buffers returned instructions in a prefetch queue of DEPTH entries and presents them to decode over a valid/ready interface.
- Supports redirect (branch/jump) with a queue flush, and discards responses still in flight at the time of the redirect.

---
 rtl/rv32i_pkg.sv | 13 +
 rtl/fetch_queue_fifo.sv | 52 +++++
 rtl/fetch_queue.sv | 88 ++++++++
 tb/tb_fetch_queue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions used by the fetch and decode stages.
// Holds the datapath width and the fetch-entry bundle layout.
package rv32i_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous circular prefetch buffer with push, pop and flush.
// Works for any depth of 2 or more, not just powers of two.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import rv32i_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            unique case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, request credits and prefetch queue.
// Redirects flush the queue and drop responses already in flight.
module fetch_queue #(
    parameter int               XLEN     = rv32i_pkg::XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    import rv32i_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     count;
    logic [CW:0]       credit_sum;
    logic [2*XLEN-1:0] head;
    logic [XLEN-1:0]   target;
    logic              accept;
    logic              resp_ok;
    logic              push;
    logic              pop;

    // In-flight requests reserve queue slots, so a push never overflows.
    assign credit_sum     = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid
                            && (credit_sum < (CW+1)'(DEPTH));
    assign imem_addr      = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign resp_ok        = imem_resp_valid && (outstanding != '0);
    assign push           = resp_ok && !redirect_valid && (discard == '0);
    assign instr_valid    = !rst && (count != '0);
    assign pop            = instr_valid && instr_ready && !redirect_valid;
    assign instr          = instr_valid ? head[XLEN-1:0] : '0;
    assign instr_pc       = instr_valid ? head[2*XLEN-1:XLEN] : '0;
    assign target         = {redirect_pc[XLEN-1:2], 2'b00};

    fetch_fifo #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({resp_pc, imem_resp_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            pc          <= target;
            resp_pc     <= target;
            outstanding <= outstanding - CW'(resp_ok);
            discard     <= outstanding - CW'(resp_ok);
        end else begin
            if (accept) pc <= pc + XLEN'(INSTR_BYTES);
            outstanding <= outstanding + CW'(accept) - CW'(resp_ok);
            if (resp_ok) begin
                if (discard != '0) discard <= discard - 1'b1;
                else resp_pc <= resp_pc + XLEN'(INSTR_BYTES);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table, directed corners, random traffic.
// An in-order memory model feeds responses; a credit/stream model checks.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        rst;
        logic        chk_addr;
        logic [31:0] addr;
        logic        rv;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    mreq_t       mq[$];
    vec_t        vt[9];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic        mready;
    int          out_n = 0;
    int          disc_n = 0;
    int          buf_n = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_addr = RESET_PC;
    logic        s_rv, s_iv, s_pop, s_resp;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for condition", name);
    endtask

    // One clock: drive memory, sample before the edge, then advance models.
    task automatic cycle();
        logic  acc, pop, vresp, r, rd;
        mreq_t e;
        imem_resp_valid = 0;
        imem_resp_data  = 0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1;
            imem_resp_data  = mq[0].addr ^ KEY;
        end
        imem_req_ready = mready;
        #1;
        s_rv = imem_req_valid; s_iv = instr_valid; s_addr = imem_addr;
        s_pc = instr_pc; s_instr = instr; s_resp = imem_resp_valid;
        r = rst; rd = redirect_valid;
        chk("req_valid", 32'(s_rv),
            32'(!r && !rd && (buf_n + out_n < DEPTH)));
        chk("instr_valid", 32'(s_iv), 32'(!r && buf_n > 0));
        if (!s_iv) chk("idle_zero", s_instr | s_pc, 32'h0);
        acc = s_rv && mready;
        if (acc) chk("req_addr", s_addr, exp_addr);
        pop = s_iv && instr_ready && !rd && !r;
        s_pop = pop;
        if (pop) begin
            chk("instr_pc", s_pc, exp_pc);
            chk("instr_data", s_instr, s_pc ^ KEY);
        end
        vresp = s_resp && out_n > 0;
        @(posedge clk);
        if (r) begin
            out_n = 0; disc_n = 0; buf_n = 0;
            exp_pc = RESET_PC; exp_addr = RESET_PC;
        end else if (rd) begin
            exp_pc = redirect_pc & ~32'd3;
            exp_addr = exp_pc;
            out_n -= int'(vresp);
            disc_n = out_n;
            buf_n = 0;
        end else begin
            if (acc) begin exp_addr += 4; out_n++; end
            if (vresp) begin
                out_n--;
                if (disc_n > 0) disc_n--;
                else buf_n++;
            end
            if (pop) begin buf_n--; exp_pc += 4; end
        end
        if (s_resp) e = mq.pop_front();
        if (acc) begin
            e.addr = s_addr;
            e.due  = cyc + int'($urandom_range(lat_lo, lat_hi));
            mq.push_back(e);
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int n, got;
        rst = 1; mready = 1; instr_ready = 1;
        redirect_valid = 0; redirect_pc = 0;
        imem_req_ready = 1; imem_resp_valid = 0; imem_resp_data = 0;

        vt[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00};
        vt[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 1'b0, 32'h00};
        vt[2] = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 32'h00};
        vt[3] = '{1'b0, 1'b1, 32'h04, 1'b1, 1'b0, 32'h00};
        vt[4] = '{1'b0, 1'b1, 32'h08, 1'b1, 1'b1, 32'h00};
        vt[5] = '{1'b0, 1'b1, 32'h0C, 1'b1, 1'b1, 32'h04};
        vt[6] = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h08};
        vt[7] = '{1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h0C};
        vt[8] = '{1'b0, 1'b1, 32'h18, 1'b1, 1'b1, 32'h10};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            rst = vt[i].rst;
            cycle();
            chk("tbl_req_valid", 32'(s_rv), 32'(vt[i].rv));
            if (vt[i].chk_addr) chk("tbl_addr", s_addr, vt[i].addr);
            chk("tbl_instr_valid", 32'(s_iv), 32'(vt[i].iv));
            if (vt[i].iv) begin
                chk("tbl_instr_pc", s_pc, vt[i].pc);
                chk("tbl_instr", s_instr, vt[i].pc ^ KEY);
            end
        end

        instr_ready = 0;
        repeat (10) cycle();
        chk("bp_req_off", 32'(s_rv), 32'h0);
        chk("bp_head_valid", 32'(s_iv), 32'h1);
        instr_ready = 1;
        repeat (8) cycle();

        mready = 0;
        cycle();
        chk("stall_addr0", s_addr, exp_addr);
        n = 0;
        repeat (4) begin
            logic [31:0] a0;
            a0 = exp_addr;
            cycle();
            chk("stall_addr", s_addr, a0);
        end
        chk("stall_drain", 32'(s_iv), 32'h0);

        lat_lo = 3; lat_hi = 3;
        mready = 1;
        n = 0;
        while (out_n != 2 && n < 20) begin cycle(); n++; end
        if (n >= 20) timeout("rd2_setup");
        redirect_valid = 1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 0;
        got = 0; n = 0;
        while (got < 2 && n < 30) begin
            cycle();
            if (s_pop) begin
                if (got == 0) chk("rd2_first", s_pc, 32'h100);
                else chk("rd2_second", s_pc, 32'h104);
                got++;
            end
            n++;
        end
        if (got < 2) timeout("rd2_pops");

        lat_lo = 1; lat_hi = 1;
        repeat (6) cycle();
        n = 0;
        while (!(mq.size() > 0 && mq[0].due <= cyc && buf_n > 0) && n < 20) begin
            cycle(); n++;
        end
        if (n >= 20) timeout("coinc_setup");
        redirect_valid = 1; redirect_pc = 32'h40;
        cycle();
        chk("coinc_resp", 32'(s_resp), 32'h1);
        chk("coinc_head", 32'(s_iv), 32'h1);
        redirect_valid = 0;
        cycle();
        chk("coinc_empty", 32'(s_iv), 32'h0);
        redirect_valid = 1; redirect_pc = 32'h203;
        cycle();
        redirect_valid = 0;
        cycle();
        chk("misalign_addr", s_addr, 32'h200);
        repeat (10) cycle();

        lat_lo = 3; lat_hi = 3;
        instr_ready = 0;
        n = 0;
        while (!(out_n + buf_n == DEPTH && out_n >= 1 && buf_n >= 1) && n < 30) begin
            cycle(); n++;
        end
        if (n >= 30) timeout("rst_setup");
        rst = 1; mready = 0;
        cycle();
        rst = 0;
        cycle();
        chk("rst_flush", 32'(s_iv), 32'h0);
        n = 0;
        while (mq.size() > 0 && n < 10) begin
            cycle();
            chk("late_ignored", 32'(s_iv), 32'h0);
            n++;
        end
        if (mq.size() > 0) timeout("rst_drain");
        mready = 1; instr_ready = 1;
        got = 0; n = 0;
        while (got == 0 && n < 20) begin
            cycle();
            if (s_pop) begin
                chk("restart_pc", s_pc, RESET_PC);
                got++;
            end
            n++;
        end
        if (got == 0) timeout("restart");

        lat_lo = 1; lat_hi = 4;
        repeat (400) begin
            mready = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom & 32'h0000_FFFF;
            cycle();
        end
        redirect_valid = 0;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
